// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants, types and helpers for the VGA text scanner
// Default 640x480@60 geometry, 16x32 character cells and the text RAM word layout.
package vga_text_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int CNT_W        = 10;
  localparam int CELL_W       = 16;
  localparam int CELL_H       = 32;
  localparam int TEXT_COLUMNS = VGA_H_VISIBLE / CELL_W;
  localparam int TEXT_ROWS    = VGA_V_VISIBLE / CELL_H;
  localparam int BLINK_BITS_DEFAULT = 5;

  localparam int CHAR_LSB = 0;
  localparam int CHAR_W   = 7;
  localparam int FG_LSB   = 7;
  localparam int BG_LSB   = 19;
  localparam int RGB_W    = 12;

  typedef logic [RGB_W-1:0] rgb444_t;

  // row*40 as (row<<5)+(row<<3); the largest visible cell (14,39) gives 599, inside 10 bits
  function automatic logic [9:0] cell_address(input logic [4:0] cell_row,
                                              input logic [5:0] cell_col);
    return {cell_row, 5'b0} + {2'b0, cell_row, 3'b0} + {4'b0, cell_col};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - horizontal/vertical pixel counters with sync and visible-area decode
// Decodes are combinational from the current counters; the caller registers them.
module vga_timing
  import vga_text_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       visible,
  output logic       frame_wrap
);

  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);

  logic h_wrap;

  assign h_wrap = (h_count == H_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_wrap) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign hsync_n    = !((h_count >= H_SYNC_FIRST) && (h_count <= H_SYNC_LAST));
  assign vsync_n    = !((v_count >= V_SYNC_FIRST) && (v_count <= V_SYNC_LAST));
  assign visible    = (h_count < H_VIS) && (v_count < V_VIS);
  assign frame_wrap = h_wrap && (v_count == V_LAST);

endmodule

// File: rtl/vga_text_scanner.sv
// rtl/vga_text_scanner.sv - VGA timing plus text-cell fetch with a blinking inverse cursor
// Stage 0 drives the RAM address; stage 1 aligns sync, cell position and the RAM word.
module vga_text_scanner
  import vga_text_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int BLINK_BITS = BLINK_BITS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] Text_Data,
  input  logic [5:0]  cursor_column,
  input  logic [3:0]  cursor_row,
  input  logic        cursor_enable,
  output logic [9:0]  Text_Address,
  output logic        H_output,
  output logic        V_output,
  output logic        picture,
  output logic [4:0]  row,
  output logic [3:0]  column,
  output logic [6:0]  character,
  output logic [11:0] foreground,
  output logic [11:0] background,
  output logic        frame_start
);

  logic [9:0]            h_count;
  logic [9:0]            v_count;
  logic                  hsync_n;
  logic                  vsync_n;
  logic                  visible;
  logic                  frame_wrap;
  logic [5:0]            cell_col;
  logic [4:0]            cell_row;
  logic                  hit_next;
  logic                  cursor_hit;
  logic [BLINK_BITS-1:0] frame_count;
  rgb444_t               fg_word;
  rgb444_t               bg_word;
  logic                  text_data_unused;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clock      (clock),
    .reset_n    (reset_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .visible    (visible),
    .frame_wrap (frame_wrap)
  );

  assign cell_col     = h_count[9:4];
  assign cell_row     = v_count[9:5];
  assign Text_Address = visible ? cell_address(cell_row, cell_col) : '0;

  // Gating with visible keeps out-of-range cursor positions from ever matching
  assign hit_next = cursor_enable && visible && frame_count[BLINK_BITS-1]
                    && (cell_col == cursor_column) && (cell_row == {1'b0, cursor_row});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      H_output    <= 1'b1;
      V_output    <= 1'b1;
      picture     <= 1'b0;
      row         <= '0;
      column      <= '0;
      frame_start <= 1'b0;
      cursor_hit  <= 1'b0;
      frame_count <= '0;
    end else begin
      H_output    <= hsync_n;
      V_output    <= vsync_n;
      picture     <= visible;
      row         <= v_count[4:0];
      column      <= h_count[3:0];
      frame_start <= (h_count == '0) && (v_count == '0);
      cursor_hit  <= hit_next;
      if (frame_wrap) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  assign fg_word          = Text_Data[FG_LSB +: RGB_W];
  assign bg_word          = Text_Data[BG_LSB +: RGB_W];
  assign text_data_unused = Text_Data[31];

  always_comb begin
    character  = '0;
    foreground = '0;
    background = '0;
    if (picture) begin
      character  = Text_Data[CHAR_LSB +: CHAR_W];
      foreground = cursor_hit ? bg_word : fg_word;
      background = cursor_hit ? fg_word : bg_word;
    end
  end

endmodule

// File: tb/tb_vga_text_scanner.sv
// tb/tb_vga_text_scanner.sv - scoreboard bench for vga_text_scanner
// Full-size instance for line timing/addressing, reduced-geometry instance for frames and cursor blink.
module tb_vga_text_scanner;

  localparam int S_TA = 0, S_H = 1, S_V = 2, S_PIC = 3, S_FS = 4, S_ROW = 5, S_COL = 6;
  localparam int S_CHR = 7, S_FG = 8, S_BG = 9, S_HLOW = 10, S_VLOW = 11, S_FSCNT = 12;
  localparam int EPOCH = 1000000;

  typedef struct {
    int key;
    int ep;
    int cyc;
    int sel;
    int exp;
  } chk_t;

  chk_t q_f[$];
  chk_t q_s[$];
  int   total = 0;
  int   bad = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_f;
  logic rst_s;
  int   ep_f = 0;
  int   ep_s = 0;
  int   cnt_f = 0;
  int   cnt_s = 0;
  int   hlow_f = 0;
  int   vlow_s = 0;
  int   fsc_s = 0;

  logic [31:0] td_f = '0, td_s = '0;
  logic [5:0]  cc_f = '0, cc_s = '0;
  logic [3:0]  cr_f = '0, cr_s = '0;
  logic        ce_f = 1'b0, ce_s = 1'b0;
  logic [9:0]  ta_f, ta_s;
  logic        h_f, h_s, v_f, v_s, pic_f, pic_s, fs_f, fs_s;
  logic [4:0]  row_f, row_s;
  logic [3:0]  col_f, col_s;
  logic [6:0]  ch_f, ch_s;
  logic [11:0] fg_f, fg_s, bg_f, bg_s;

  vga_text_scanner u_full (
    .clock(clock), .reset_n(rst_f), .Text_Data(td_f),
    .cursor_column(cc_f), .cursor_row(cr_f), .cursor_enable(ce_f),
    .Text_Address(ta_f), .H_output(h_f), .V_output(v_f), .picture(pic_f),
    .row(row_f), .column(col_f), .character(ch_f),
    .foreground(fg_f), .background(bg_f), .frame_start(fs_f)
  );

  // 80x72 total, 64x64 visible: 4x2 cells, 5760 clocks per frame, blink period 4 frames
  vga_text_scanner #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(64), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
    .BLINK_BITS(2)
  ) u_small (
    .clock(clock), .reset_n(rst_s), .Text_Data(td_s),
    .cursor_column(cc_s), .cursor_row(cr_s), .cursor_enable(ce_s),
    .Text_Address(ta_s), .H_output(h_s), .V_output(v_s), .picture(pic_s),
    .row(row_s), .column(col_s), .character(ch_s),
    .foreground(fg_s), .background(bg_s), .frame_start(fs_s)
  );

  function automatic logic [31:0] ram_word(input logic [9:0] a);
    return {1'b1, 12'h00F, 12'hF00, a[6:0]};
  endfunction

  always @(posedge clock) begin
    td_f <= ram_word(ta_f);
    td_s <= ram_word(ta_s);
  end

  always @(posedge clock or negedge rst_f)
    if (!rst_f) cnt_f <= 0; else cnt_f <= cnt_f + 1;
  always @(posedge clock or negedge rst_s)
    if (!rst_s) cnt_s <= 0; else cnt_s <= cnt_s + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      S_TA: return "Text_Address";
      S_H: return "H_output";
      S_V: return "V_output";
      S_PIC: return "picture";
      S_FS: return "frame_start";
      S_ROW: return "row";
      S_COL: return "column";
      S_CHR: return "character";
      S_FG: return "foreground";
      S_BG: return "background";
      S_HLOW: return "hsync_low_clocks";
      S_VLOW: return "vsync_low_clocks";
      default: return "frame_start_count";
    endcase
  endfunction

  function automatic int val_f(input int sel);
    case (sel)
      S_TA: return int'(ta_f);
      S_H: return int'(h_f);
      S_V: return int'(v_f);
      S_PIC: return int'(pic_f);
      S_FS: return int'(fs_f);
      S_ROW: return int'(row_f);
      S_COL: return int'(col_f);
      S_CHR: return int'(ch_f);
      S_FG: return int'(fg_f);
      S_BG: return int'(bg_f);
      S_HLOW: return hlow_f;
      default: return -1;
    endcase
  endfunction

  function automatic int val_s(input int sel);
    case (sel)
      S_TA: return int'(ta_s);
      S_H: return int'(h_s);
      S_V: return int'(v_s);
      S_PIC: return int'(pic_s);
      S_FS: return int'(fs_s);
      S_CHR: return int'(ch_s);
      S_FG: return int'(fg_s);
      S_BG: return int'(bg_s);
      S_VLOW: return vlow_s;
      S_FSCNT: return fsc_s;
      default: return -1;
    endcase
  endfunction

  // cyc = -1 means "while reset is held"; otherwise clocks since reset release
  task automatic push_f(input int ep, input int cyc, input int sel, input int exp);
    q_f.push_back('{ep * EPOCH + 1 + cyc, ep, cyc, sel, exp});
  endtask

  task automatic push_s(input int ep, input int cyc, input int sel, input int exp);
    q_s.push_back('{ep * EPOCH + 1 + cyc, ep, cyc, sel, exp});
  endtask

  always @(negedge clock) begin
    int cur;
    int act;
    chk_t e;
    if (!rst_f) begin
      hlow_f = 0;
      cur = ep_f * EPOCH;
    end else begin
      if (!h_f) hlow_f++;
      cur = ep_f * EPOCH + 1 + cnt_f;
    end
    while (q_f.size() > 0 && q_f[0].key <= cur) begin
      e = q_f.pop_front();
      total++;
      act = val_f(e.sel);
      if (e.key < cur) begin
        bad++;
        $display("FAIL full.%s ep%0d cyc%0d: skipped, required=%0h", sel_name(e.sel), e.ep, e.cyc, e.exp);
      end else if (act != e.exp) begin
        bad++;
        $display("FAIL full.%s ep%0d cyc%0d: actual=%0h required=%0h", sel_name(e.sel), e.ep, e.cyc, act, e.exp);
      end
    end
  end

  always @(negedge clock) begin
    int cur;
    int act;
    chk_t e;
    if (!rst_s) begin
      vlow_s = 0;
      fsc_s = 0;
      cur = ep_s * EPOCH;
    end else begin
      if (!v_s) vlow_s++;
      if (fs_s) fsc_s++;
      cur = ep_s * EPOCH + 1 + cnt_s;
    end
    while (q_s.size() > 0 && q_s[0].key <= cur) begin
      e = q_s.pop_front();
      total++;
      act = val_s(e.sel);
      if (e.key < cur) begin
        bad++;
        $display("FAIL small.%s ep%0d cyc%0d: skipped, required=%0h", sel_name(e.sel), e.ep, e.cyc, e.exp);
      end else if (act != e.exp) begin
        bad++;
        $display("FAIL small.%s ep%0d cyc%0d: actual=%0h required=%0h", sel_name(e.sel), e.ep, e.cyc, act, e.exp);
      end
    end
  end

  task automatic push_reset_state_f(input int ep);
    push_f(ep, -1, S_H, 1);   push_f(ep, -1, S_V, 1);   push_f(ep, -1, S_PIC, 0);
    push_f(ep, -1, S_FS, 0);  push_f(ep, -1, S_ROW, 0); push_f(ep, -1, S_COL, 0);
    push_f(ep, -1, S_CHR, 0); push_f(ep, -1, S_FG, 0);  push_f(ep, -1, S_BG, 0);
    push_f(ep, -1, S_TA, 0);
  endtask

  initial begin : stim_full
    rst_f = 1'b1;
    #1 rst_f = 1'b0;
    push_reset_state_f(0);
    push_f(0, 0, S_TA, 0);
    push_f(0, 1, S_PIC, 1); push_f(0, 1, S_FS, 1); push_f(0, 1, S_ROW, 0); push_f(0, 1, S_COL, 0);
    push_f(0, 1, S_H, 1);   push_f(0, 1, S_V, 1);  push_f(0, 1, S_CHR, 0);
    push_f(0, 1, S_FG, 'hF00); push_f(0, 1, S_BG, 'h00F);
    push_f(0, 2, S_FS, 0);  push_f(0, 2, S_COL, 1);
    push_f(0, 15, S_TA, 0);
    push_f(0, 16, S_TA, 1); push_f(0, 16, S_COL, 15);
    push_f(0, 17, S_CHR, 1); push_f(0, 17, S_COL, 0);
    push_f(0, 640, S_TA, 0); push_f(0, 640, S_PIC, 1); push_f(0, 640, S_CHR, 39);
    push_f(0, 641, S_PIC, 0); push_f(0, 641, S_CHR, 0); push_f(0, 641, S_FG, 0); push_f(0, 641, S_BG, 0);
    push_f(0, 656, S_H, 1); push_f(0, 657, S_H, 0); push_f(0, 752, S_H, 0); push_f(0, 753, S_H, 1);
    push_f(0, 800, S_HLOW, 96);
    push_f(0, 1456, S_H, 1); push_f(0, 1457, S_H, 0);
    push_f(0, 25600, S_TA, 40); push_f(0, 25600, S_ROW, 31); push_f(0, 25600, S_PIC, 0);
    push_f(0, 25601, S_ROW, 0); push_f(0, 25601, S_CHR, 40); push_f(0, 25601, S_PIC, 1);
    push_f(0, 26699, S_PIC, 1); push_f(0, 26699, S_COL, 10); push_f(0, 26699, S_ROW, 1);
    push_f(0, 26699, S_CHR, 58); push_f(0, 26699, S_FG, 'hF00);
    repeat (3) @(posedge clock);
    #1 rst_f = 1'b1;
    for (int i = 0; i < 30000 && cnt_f < 26700; i++) begin
      @(posedge clock);
      #2;
    end
    // Counters now sit at h=300,v=33; drop reset between edges
    push_reset_state_f(1);
    push_f(1, 0, S_TA, 0);
    push_f(1, 1, S_FS, 1); push_f(1, 1, S_PIC, 1); push_f(1, 1, S_COL, 0); push_f(1, 1, S_ROW, 0);
    push_f(1, 2, S_FS, 0);
    push_f(1, 3, S_COL, 2);
    ep_f = 1;
    rst_f = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst_f = 1'b1;
  end

  initial begin : stim_small
    rst_s = 1'b1;
    ce_s = 1'b1; cc_s = 6'd3; cr_s = 4'd1;
    #1 rst_s = 1'b0;
    push_s(0, -1, S_FG, 0); push_s(0, -1, S_PIC, 0); push_s(0, -1, S_H, 1);
    push_s(0, 0, S_TA, 0);
    push_s(0, 1, S_FS, 1); push_s(0, 1, S_PIC, 1);
    push_s(0, 64, S_PIC, 1);
    push_s(0, 65, S_PIC, 0); push_s(0, 65, S_CHR, 0);
    push_s(0, 2609, S_FG, 'hF00); push_s(0, 2609, S_BG, 'h00F); push_s(0, 2609, S_CHR, 43);
    push_s(0, 5103, S_TA, 43);
    push_s(0, 5120, S_TA, 0);
    push_s(0, 5280, S_V, 1); push_s(0, 5281, S_V, 0); push_s(0, 5440, S_V, 0); push_s(0, 5441, S_V, 1);
    push_s(0, 5760, S_VLOW, 160);
    push_s(0, 5761, S_FS, 1); push_s(0, 5762, S_FS, 0);
    push_s(0, 8369, S_FG, 'hF00); push_s(0, 8369, S_BG, 'h00F);
    push_s(0, 11521, S_FS, 1); push_s(0, 11521, S_FSCNT, 3);
    push_s(0, 14128, S_FG, 'hF00); push_s(0, 14128, S_BG, 'h00F);
    push_s(0, 14129, S_FG, 'h00F); push_s(0, 14129, S_BG, 'hF00); push_s(0, 14129, S_CHR, 43);
    push_s(0, 19889, S_FG, 'h00F); push_s(0, 19889, S_BG, 'hF00);
    push_s(0, 22384, S_FG, 'h00F); push_s(0, 22384, S_BG, 'hF00);
    push_s(0, 25649, S_FG, 'hF00); push_s(0, 25649, S_BG, 'h00F);
    push_s(0, 37169, S_FG, 'hF00); push_s(0, 37169, S_BG, 'h00F);
    push_s(0, 40321, S_FG, 'h00F); push_s(0, 40321, S_BG, 'hF00);
    push_s(0, 42929, S_FG, 'hF00); push_s(0, 42929, S_BG, 'h00F);
    repeat (3) @(posedge clock);
    #1 rst_s = 1'b1;
    for (int i = 0; i < 40000 && cnt_s < 35000; i++) begin
      @(posedge clock);
      #1;
    end
    ce_s = 1'b0;
    for (int i = 0; i < 10000 && cnt_s < 39000; i++) begin
      @(posedge clock);
      #1;
    end
    ce_s = 1'b1; cc_s = 6'd0; cr_s = 4'd0;
  end

  initial begin : finish_run
    #20;
    for (int i = 0; i < 50000 && !(rst_s && cnt_s >= 43000); i++) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    #1;
    while (q_f.size() > 0) begin
      total++; bad++;
      $display("FAIL full.%s ep%0d cyc%0d: never reached", sel_name(q_f[0].sel), q_f[0].ep, q_f[0].cyc);
      void'(q_f.pop_front());
    end
    while (q_s.size() > 0) begin
      total++; bad++;
      $display("FAIL small.%s ep%0d cyc%0d: never reached", sel_name(q_s[0].sel), q_s[0].ep, q_s[0].cyc);
      void'(q_s.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
